// File: rtl/minimization_pkg.sv
// -----------------------------------------------------------------------------
// minimization_pkg
//
// Shared types and constants for the mu-operator (minimization) block.
//   - state_e : FSM state encoding (IDLE, LAUNCH, WAIT, CHECK, DONE)
//   - CMP_EQ  : stop when the child result equals the criterion
//   - CMP_GE  : stop when the child result is >= the criterion (unsigned)
// -----------------------------------------------------------------------------
package minimization_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int unsigned CMP_EQ = 0;
    localparam int unsigned CMP_GE = 1;

endpackage : minimization_pkg

// File: rtl/minimization_cmp.sv
// -----------------------------------------------------------------------------
// minimization_cmp
//
// Purely combinational stop-criterion test applied to a captured child result.
//
// Parameters:
//   BW       - width of the child result
//   CRIT     - criterion constant
//   CMP_MODE - CMP_EQ: match when f_res == CRIT
//              CMP_GE: match when f_res >= CRIT (unsigned)
// Ports:
//   f_res  in  BW  child result under test
//   match  out 1   criterion satisfied
// -----------------------------------------------------------------------------
module minimization_cmp
    import minimization_pkg::*;
#(
    parameter int unsigned    BW       = 16,
    parameter logic [BW-1:0]  CRIT     = BW'(2),
    parameter int unsigned    CMP_MODE = CMP_EQ
) (
    input  logic [BW-1:0] f_res,
    output logic          match
);

    // The mode is fixed at elaboration, so only one comparator is built.
    if (CMP_MODE == CMP_GE) begin : g_ge
        assign match = (f_res >= CRIT);
    end else begin : g_eq
        assign match = (f_res == CRIT);
    end

endmodule : minimization_cmp

// File: rtl/minimization_m.sv
// -----------------------------------------------------------------------------
// minimization_m
//
// Mu-operator: on start, latches the argument vector and launches an external
// child function with (in, y) for y = 0, 1, 2, ... until the child result meets
// the criterion; returns that first y. One iteration is LAUNCH, the child
// latency spent in WAIT, then CHECK.
//
// Optional feature (compile-time macro MINIMIZATION_TIMEOUT_EN):
//   defined   - an iteration counter aborts the search in CHECK once MAXIT
//               iterations have completed without a match (err = 1,
//               res = MAXIT-1). The y-overflow abort still applies.
//   undefined - no iteration counter; MAXIT is ignored; err comes only from
//               y reaching 2^BW-1 without a match.
//
// Parameters: BW, ICNT, CRIT, CMP_MODE (CMP_EQ / CMP_GE), MAXIT
//
// Ports:
//   clk    in  1        clock, rising edge
//   rst_n  in  1        asynchronous active-low reset
//   st     in  1        start (level), sampled in IDLE
//   in     in  ICNT*BW  packed arguments, in[BW-1:0] = argument 0
//   rd     out 1        result ready, high throughout DONE
//   res    out BW       minimal y, or stop value on abort
//   err    out 1        search aborted without a match
//   f_st   out 1        child start, one-cycle pulse
//   f_in   out ICNT*BW  latched arguments to the child
//   f_y    out BW       current y to the child
//   f_rd   in  1        child ready (only looked at in WAIT)
//   f_res  in  BW       child result, valid while f_rd = 1
// -----------------------------------------------------------------------------
module minimization_m
    import minimization_pkg::*;
#(
    parameter int unsigned    BW       = 16,
    parameter int unsigned    ICNT     = 3,
    parameter logic [BW-1:0]  CRIT     = BW'(2),
    parameter int unsigned    CMP_MODE = CMP_EQ,
    parameter int unsigned    MAXIT    = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 st,
    input  logic [ICNT*BW-1:0]   in,
    output logic                 rd,
    output logic [BW-1:0]        res,
    output logic                 err,
    output logic                 f_st,
    output logic [ICNT*BW-1:0]   f_in,
    output logic [BW-1:0]        f_y,
    input  logic                 f_rd,
    input  logic [BW-1:0]        f_res
);

    localparam logic [BW-1:0] Y_MAX = '1;

    state_e               state_q, state_d;
    logic [BW-1:0]        y_q, y_d;
    logic [BW-1:0]        res_q, res_d;
    logic                 err_q, err_d;
    logic [ICNT*BW-1:0]   f_in_q, f_in_d;
    logic [BW-1:0]        fres_q, fres_d;
    logic                 match;

`ifdef MINIMIZATION_TIMEOUT_EN
    // Counts completed non-matching iterations; the abort fires in the CHECK
    // of iteration number MAXIT, so the counter never needs to reach MAXIT.
    localparam int unsigned   IW       = (MAXIT > 1) ? $clog2(MAXIT) : 1;
    localparam logic [IW-1:0] IT_LAST  = IW'(MAXIT - 1);
    localparam logic [BW-1:0] RES_TOUT = BW'(MAXIT - 1);

    logic [IW-1:0] it_q, it_d;
`endif

    // The criterion is applied to the registered child result so the compare
    // path starts at a flop rather than at the child's output.
    minimization_cmp #(
        .BW       (BW),
        .CRIT     (CRIT),
        .CMP_MODE (CMP_MODE)
    ) u_cmp (
        .f_res (fres_q),
        .match (match)
    );

    // ------------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a missing
        // assignment on any path would otherwise infer a latch.
        state_d = state_q;
        y_d     = y_q;
        res_d   = res_q;
        err_d   = err_q;
        f_in_d  = f_in_q;
        fres_d  = fres_q;
`ifdef MINIMIZATION_TIMEOUT_EN
        it_d    = it_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (st) begin
                    f_in_d  = in;
                    y_d     = '0;
`ifdef MINIMIZATION_TIMEOUT_EN
                    it_d    = '0;
`endif
                    state_d = LAUNCH;
                end
            end

            LAUNCH: begin
                state_d = WAIT;
            end

            WAIT: begin
                if (f_rd) begin
                    fres_d  = f_res;
                    state_d = CHECK;
                end
            end

            CHECK: begin
                if (match) begin
                    res_d   = y_q;
                    state_d = DONE;
                end
`ifdef MINIMIZATION_TIMEOUT_EN
                else if (it_q == IT_LAST) begin
                    err_d   = 1'b1;
                    res_d   = RES_TOUT;
                    state_d = DONE;
                end
`endif
                // Stop at the top of the range instead of wrapping to 0.
                else if (y_q == Y_MAX) begin
                    err_d   = 1'b1;
                    res_d   = y_q;
                    state_d = DONE;
                end else begin
                    y_d     = y_q + 1'b1;
`ifdef MINIMIZATION_TIMEOUT_EN
                    it_d    = it_q + 1'b1;
`endif
                    state_d = LAUNCH;
                end
            end

            DONE: begin
                // A held start does not retrigger; st must drop first.
                if (!st) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            f_in_q  <= '0;
            fres_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            y_q     <= y_d;
            res_q   <= res_d;
            err_q   <= err_d;
            f_in_q  <= f_in_d;
            fres_q  <= fres_d;
        end
    end

`ifdef MINIMIZATION_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            it_q <= '0;
        end else begin
            it_q <= it_d;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // rd and f_st decode straight from the state register: they are glitch-free,
    // clear asynchronously with reset, and f_st cannot repeat back-to-back
    // because LAUNCH always moves to WAIT.
    assign rd   = (state_q == DONE);
    assign f_st = (state_q == LAUNCH);
    assign res  = res_q;
    assign err  = err_q;
    assign f_in = f_in_q;
    assign f_y  = y_q;

endmodule : minimization_m
